// File: rtl/render_pkg.sv
// Shared constants and types for the streaming screen renderer.
package render_pkg;

  localparam logic [23:0] WHITE = 24'hffffff;
  localparam logic [23:0] GREEN = 24'h08ff08;
  localparam logic [23:0] BROWN = 24'h8b4513;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

  localparam int COORD_W_DFLT = 10;
  typedef logic [COORD_W_DFLT-1:0] coord_t;

endpackage

// File: rtl/render_stream_rect_hit.sv
// Combinational point-in-rectangle test; compares one bit wider so far edges never wrap.
module rect_hit #(
  parameter int W       = 40,
  parameter int H       = 5,
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] rx,
  input  logic [COORD_W-1:0] ry,
  input  logic               en,
  output logic               hit
);
  localparam logic [COORD_W:0] W_M1 = (COORD_W+1)'(W-1);
  localparam logic [COORD_W:0] H_M1 = (COORD_W+1)'(H-1);

  logic [COORD_W:0] px_e, py_e, rx_e, ry_e;

  assign px_e = {1'b0, px};
  assign py_e = {1'b0, py};
  assign rx_e = {1'b0, rx};
  assign ry_e = {1'b0, ry};

  assign hit = en && (px_e >= rx_e) && (px_e <= rx_e + W_M1)
                  && (py_e >= ry_e) && (py_e <= ry_e + H_M1);
endmodule

// File: rtl/render_stream.sv
// Streams one raster-order pixel per cycle over valid/ready from a snapshot of the doodle/blocks.
// Optional RENDER_COLLIDE_EN adds a per-frame doodle/block overlap flag on port collide.
module render_stream import render_pkg::*; #(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 700,
  parameter int BLOCK_WIDTH   = 40,
  parameter int BLOCK_HEIGHT  = 5,
  parameter int DOODLE_SIZE   = 20,
  parameter int MAX_BLOCKS    = 16,
  parameter int COORD_W       = 10,
  parameter int COLOR_W       = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic [COORD_W-1:0]            doodle_x,
  input  logic [COORD_W-1:0]            doodle_y,
  input  logic [MAX_BLOCKS*COORD_W-1:0] blocks_x,
  input  logic [MAX_BLOCKS*COORD_W-1:0] blocks_y,
  input  logic [MAX_BLOCKS-1:0]         block_active,
  output logic                          busy,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [COORD_W-1:0]            pix_x,
  output logic [COORD_W-1:0]            pix_y,
  output logic [COLOR_W-1:0]            pix_color,
`ifdef RENDER_COLLIDE_EN
  output logic                          collide,
`endif
  output logic                          pix_sof,
  output logic                          pix_eol,
  output logic                          pix_eof
);
  localparam int STAGES = 2;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_WIDTH-1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_HEIGHT-1);

  // Keep the MSBs of the 24-bit colour, padding or dropping on the LSB side.
  function automatic logic [COLOR_W-1:0] fit(input logic [23:0] c);
    logic [COLOR_W+23:0] t;
    t = {c, {COLOR_W{1'b0}}};
    return t[COLOR_W+23 -: COLOR_W];
  endfunction

  state_t state;
  // [0] counter holds a live coordinate, [1] stage-1 hits, [2] output register
  logic [STAGES:0] vld_pipe;

  logic [COORD_W-1:0] cx, cy, snap_dx, snap_dy;
  logic [MAX_BLOCKS-1:0][COORD_W-1:0] snap_bx, snap_by;
  logic [MAX_BLOCKS-1:0] snap_act, blk_hit;
  logic doodle_hit;
  logic [COORD_W-1:0] s1_x, s1_y;
  logic s1_dh, s1_bh;
  logic advance, last_issue, eof_xfer, start;

  assign advance    = !vld_pipe[STAGES] || pix_ready;
  assign last_issue = vld_pipe[0] && (cx == X_LAST) && (cy == Y_LAST);
  assign eof_xfer   = pix_valid && pix_ready && pix_eof;
  assign start      = (state == IDLE) && frame_start;
  assign pix_valid  = vld_pipe[STAGES];
  assign busy       = (state != IDLE);

  rect_hit #(.W(DOODLE_SIZE), .H(DOODLE_SIZE), .COORD_W(COORD_W)) u_doodle (
    .px(cx), .py(cy), .rx(snap_dx), .ry(snap_dy), .en(1'b1), .hit(doodle_hit)
  );

  for (genvar b = 0; b < MAX_BLOCKS; b++) begin : g_blk
    rect_hit #(.W(BLOCK_WIDTH), .H(BLOCK_HEIGHT), .COORD_W(COORD_W)) u_blk (
      .px(cx), .py(cy), .rx(snap_bx[b]), .ry(snap_by[b]), .en(snap_act[b]), .hit(blk_hit[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cx       <= '0;
      cy       <= '0;
      snap_dx  <= '0;
      snap_dy  <= '0;
      snap_bx  <= '0;
      snap_by  <= '0;
      snap_act <= '0;
    end else begin
      case (state)
        IDLE: if (frame_start) begin
          state    <= RUN;
          cx       <= '0;
          cy       <= '0;
          snap_dx  <= doodle_x;
          snap_dy  <= doodle_y;
          snap_bx  <= blocks_x;
          snap_by  <= blocks_y;
          snap_act <= block_active;
        end
        RUN: if (advance) begin
          if (last_issue) state <= DRAIN;
          else if (cx == X_LAST) begin
            cx <= '0;
            cy <= cy + COORD_W'(1);
          end else cx <= cx + COORD_W'(1);
        end
        DRAIN: if (eof_xfer) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Global stall: the whole pipe moves only when the output slot frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_dh     <= 1'b0;
      s1_bh     <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
    end else begin
      if (start) vld_pipe[0] <= 1'b1;
      else if (advance && last_issue) vld_pipe[0] <= 1'b0;
      if (advance) begin
        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        s1_x      <= cx;
        s1_y      <= cy;
        s1_dh     <= doodle_hit;
        s1_bh     <= |blk_hit;
        pix_x     <= s1_x;
        pix_y     <= s1_y;
        pix_color <= s1_dh ? fit(GREEN) : (s1_bh ? fit(BROWN) : fit(WHITE));
        pix_sof   <= vld_pipe[1] && (s1_x == '0) && (s1_y == '0);
        pix_eol   <= vld_pipe[1] && (s1_x == X_LAST);
        pix_eof   <= vld_pipe[1] && (s1_x == X_LAST) && (s1_y == Y_LAST);
      end
    end
  end

`ifdef RENDER_COLLIDE_EN
  logic hit_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_flag <= 1'b0;
      collide  <= 1'b0;
    end else begin
      if (start) hit_flag <= 1'b0;
      else if (vld_pipe[1] && s1_dh && s1_bh) hit_flag <= 1'b1;
      if (eof_xfer) collide <= hit_flag;
    end
  end
`endif

endmodule

// File: tb/tb_render_stream.sv
// Randomised bench for render_stream on an 8x4 screen against a pixel-rule reference model.
module tb_render_stream;
  localparam int W = 8, H = 4, BW = 3, BH = 1, DS = 2, NB = 2, CW = 4, COLW = 24;
  localparam int NPIX = W * H;

  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, pix_ready = 1'b0;
  logic [CW-1:0] doodle_x = '0, doodle_y = '0;
  logic [NB*CW-1:0] blocks_x = '0, blocks_y = '0;
  logic [NB-1:0] block_active = '0;
  logic busy, pix_valid, pix_sof, pix_eol, pix_eof;
  logic [CW-1:0] pix_x, pix_y;
  logic [COLW-1:0] pix_color;
`ifdef RENDER_COLLIDE_EN
  logic collide;
`endif

  int total = 0, bad = 0;
  int s_dx, s_dy;
  int s_bx[NB], s_by[NB];
  bit s_act[NB];

  always #5 clk = ~clk;

  render_stream #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH),
    .DOODLE_SIZE(DS), .MAX_BLOCKS(NB), .COORD_W(CW), .COLOR_W(COLW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .doodle_x(doodle_x), .doodle_y(doodle_y),
    .blocks_x(blocks_x), .blocks_y(blocks_y), .block_active(block_active),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
`ifdef RENDER_COLLIDE_EN
    .collide(collide),
`endif
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  function automatic bit in_rect(int px, int py, int rx, int ry, int w, int h);
    return px >= rx && px < rx + w && py >= ry && py < ry + h;
  endfunction

  function automatic bit any_block(int x, int y);
    for (int i = 0; i < NB; i++)
      if (s_act[i] && in_rect(x, y, s_bx[i], s_by[i], BW, BH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [23:0] ref_color(int x, int y);
    if (in_rect(x, y, s_dx, s_dy, DS, DS)) return 24'h08ff08;
    if (any_block(x, y)) return 24'h8b4513;
    return 24'hffffff;
  endfunction

  function automatic logic ref_collide();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (in_rect(x, y, s_dx, s_dy, DS, DS) && any_block(x, y)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_word(int n);
    int x, y;
    x = n % W;
    y = n / W;
    return {27'b0, 1'b1, 1'b1, CW'(x), CW'(y), ref_color(x, y),
            x == 0 && y == 0, x == W - 1, x == W - 1 && y == H - 1};
  endfunction

  function automatic logic [63:0] out_word();
    return {27'b0, busy, pix_valid, pix_x, pix_y, pix_color, pix_sof, pix_eol, pix_eof};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_objs(input int dx, input int dy, input int bx0, input int by0,
                          input int bx1, input int by1, input logic [1:0] act);
    doodle_x = CW'(dx);
    doodle_y = CW'(dy);
    blocks_x = {CW'(bx1), CW'(bx0)};
    blocks_y = {CW'(by1), CW'(by0)};
    block_active = act;
  endtask

  task automatic rand_objs();
    set_objs($urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9),
             $urandom_range(0, 5), $urandom_range(0, 9), $urandom_range(0, 5),
             2'($urandom_range(0, 3)));
  endtask

  // One frame: latency, per-transfer pixel check, stall stability, end-of-frame state.
  task automatic run_frame(input bit rand_ready, input bit midchange, input bit fs_eof,
                           input int rst_at);
    int n, cnt;
    bit stalled, fs_mid, did, done;
    logic [63:0] held;
    n = 0; cnt = 0; stalled = 0; fs_mid = 0; did = 0; done = 0; held = '0;
    @(negedge clk);
    frame_start = 1'b1;
    pix_ready = 1'b1;
    s_dx = int'(doodle_x);
    s_dy = int'(doodle_y);
    for (int i = 0; i < NB; i++) begin
      s_bx[i] = int'(blocks_x[i*CW +: CW]);
      s_by[i] = int'(blocks_y[i*CW +: CW]);
      s_act[i] = block_active[i];
    end
    @(negedge clk);
    frame_start = 1'b0;
    check("lat0", {busy, pix_valid}, 2'b10);
    @(negedge clk);
    check("lat1", {busy, pix_valid}, 2'b10);
    @(negedge clk);
    check("lat2", {busy, pix_valid, pix_sof}, 3'b111);
    while (!done && n < NPIX && cnt < 400) begin
      if (stalled) check("stall", out_word(), held);
      if (fs_mid) begin
        frame_start = 1'b0;
        fs_mid = 0;
      end
      if (midchange && n == 5 && !did) begin
        did = 1;
        doodle_x = doodle_x + CW'(3);
        blocks_x = ~blocks_x;
        block_active = ~block_active;
        frame_start = 1'b1;
        fs_mid = 1;
      end
      if (rst_at >= 0 && n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid", {busy, pix_valid, pix_sof, pix_eol, pix_eof}, 5'b0);
`ifdef RENDER_COLLIDE_EN
        check("rst_collide", collide, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        done = 1;
      end else begin
        pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pix_valid && pix_ready) begin
          check($sformatf("pix%0d", n), out_word(), exp_word(n));
          if (fs_eof && n == NPIX - 1) frame_start = 1'b1;
          n++;
          stalled = 0;
        end else if (pix_valid) begin
          stalled = 1;
          held = out_word();
        end else stalled = 0;
        @(negedge clk);
        cnt++;
      end
    end
    if (!done) begin
      frame_start = 1'b0;
      check("xfer_count", 64'(n), 64'(NPIX));
      check("idle_after_eof", {busy, pix_valid}, 2'b00);
      repeat (3) @(negedge clk);
      check("no_restart", {busy, pix_valid}, 2'b00);
`ifdef RENDER_COLLIDE_EN
      check("collide", collide, ref_collide());
`endif
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out", out_word(), 64'b0);
`ifdef RENDER_COLLIDE_EN
    check("reset_collide", collide, 1'b0);
`endif
    rst_n = 1'b1;

    set_objs(0, 0, 4, 2, 0, 0, 2'b01);   // basic frame
    run_frame(0, 0, 0, -1);
    set_objs(4, 1, 4, 2, 0, 0, 2'b01);   // doodle over block
    run_frame(0, 0, 0, -1);
    set_objs(0, 0, 6, 3, 0, 0, 2'b01);   // right/bottom clipping, start at eof ignored
    run_frame(0, 0, 1, -1);
    rand_objs();
    run_frame(1, 0, 0, -1);
    rand_objs();
    run_frame(1, 1, 1, -1);              // inputs change and start pulse mid-frame
    run_frame(0, 0, 0, -1);              // new values take effect
    rand_objs();
    run_frame(1, 0, 0, 10);              // reset mid-frame
    run_frame(0, 0, 0, -1);
    repeat (4) begin
      rand_objs();
      run_frame(1, 0, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
